// File: rtl/regfile4_pkg.sv
// regfile4_pkg
// Shared definitions for the four-entry one-hot register file: entry count,
// read address width, the one-hot select type and the one-hot legality check.
// The legality check is also used by decoder benches.
package regfile4_pkg;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;

  typedef logic [NUM_REGS-1:0] sel_t;

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input sel_t sel);
    int unsigned n_set;
    n_set = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n_set += 32'(sel[i]);
    end
    return (n_set == 1);
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// regfile_cell
// One WIDTH-bit storage register with write enable.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - synchronous active-low reset, clears the register
//   i_en     - write enable
//   i_d      - write data
//   o_q      - stored value
module regfile_cell #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/onehot_regfile4.sv
// onehot_regfile4
// Four-entry register file written through a one-hot select (as produced by
// a 2-to-4 decoder). Two registered read ports with write-through bypass,
// a sticky error flag for multi-hot selects, and a wrapping write counter.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-low reset, clears all state
//   wr_sel     - one-hot write select; all-zero means no write
//   wr_data    - write data
//   rd_addr_a  - read address, port A
//   rd_addr_b  - read address, port B
//   err_clr    - clears sel_err (a new illegal select takes priority)
//   rd_data_a  - registered read data, port A
//   rd_data_b  - registered read data, port B
//   sel_err    - sticky flag, set by a select with two or more bits high
//   wr_count   - number of accepted writes, wraps
module onehot_regfile4
  import regfile4_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [ADDR_W-1:0]  rd_addr_a,
  input  logic [ADDR_W-1:0]  rd_addr_b,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   rd_data_a,
  output logic [WIDTH-1:0]   rd_data_b,
  output logic               sel_err,
  output logic [COUNT_W-1:0] wr_count
);

  logic             w_legal;
  logic             w_illegal;
  logic [WIDTH-1:0] w_q [NUM_REGS];

  logic [WIDTH-1:0]   r_rd_a;
  logic [WIDTH-1:0]   r_rd_b;
  logic               r_sel_err;
  logic [COUNT_W-1:0] r_wr_count;

  assign w_legal   = is_onehot(sel_t'(wr_sel));
  // Nonzero but not one-hot: two or more bits high.
  assign w_illegal = (|wr_sel) && !w_legal;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_en    (wr_sel[g] && w_legal),
      .i_d     (wr_data),
      .o_q     (w_q[g])
    );
  end

  // Read registers. A legal write to the addressed entry in the same cycle
  // is forwarded so the port never shows the pre-write contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= (w_legal && wr_sel[rd_addr_a]) ? wr_data : w_q[rd_addr_a];
      r_rd_b <= (w_legal && wr_sel[rd_addr_b]) ? wr_data : w_q[rd_addr_b];
    end
  end

  // Sticky error flag: set has priority over clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel_err <= 1'b0;
    end else if (w_illegal) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_count <= '0;
    end else if (w_legal) begin
      r_wr_count <= r_wr_count + COUNT_W'(1);
    end
  end

  assign rd_data_a = r_rd_a;
  assign rd_data_b = r_rd_b;
  assign sel_err   = r_sel_err;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_onehot_regfile4.sv
module tb_onehot_regfile4;

  logic       clk;
  logic       rst_n;
  logic [3:0] wr_sel;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic       err_clr;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       sel_err;
  logic [7:0] wr_count;

  // Second instance with a 4-bit counter for the wrap test.
  logic [3:0] wr_sel4;
  logic [7:0] wr_data4;
  logic [1:0] rd_addr4;
  logic       err_clr4;
  logic [7:0] rd_a4;
  logic [7:0] rd_b4;
  logic       sel_err4;
  logic [3:0] wr_count4;

  int n_chk;
  int n_pass;

  onehot_regfile4 #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .err_clr   (err_clr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .sel_err   (sel_err),
    .wr_count  (wr_count)
  );

  onehot_regfile4 #(.WIDTH(8), .COUNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (rst_n),
    .wr_sel    (wr_sel4),
    .wr_data   (wr_data4),
    .rd_addr_a (rd_addr4),
    .rd_addr_b (rd_addr4),
    .err_clr   (err_clr4),
    .rd_data_a (rd_a4),
    .rd_data_b (rd_b4),
    .sel_err   (sel_err4),
    .wr_count  (wr_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 2-to-4 decoder placed in front of the register file.
  function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] addr);
    logic [3:0] one;
    one = 4'b0001;
    return en ? (one << addr) : 4'b0000;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    wr_sel = 4'b0000; wr_data = 8'h00; rd_addr_a = 2'd0; rd_addr_b = 2'd0; err_clr = 1'b0;
    wr_sel4 = 4'b0000; wr_data4 = 8'h00; rd_addr4 = 2'd0; err_clr4 = 1'b0;
    tick(); tick();
    n_chk++; if (rd_data_a !== 8'h00) $display("FAIL reset_rd_a: got %h exp 00", rd_data_a); else n_pass++;
    n_chk++; if (rd_data_b !== 8'h00) $display("FAIL reset_rd_b: got %h exp 00", rd_data_b); else n_pass++;
    n_chk++; if (sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b exp 0", sel_err); else n_pass++;
    n_chk++; if (wr_count !== 8'd0) $display("FAIL reset_wr_count: got %0d exp 0", wr_count); else n_pass++;
    n_chk++; if (wr_count4 !== 4'd0) $display("FAIL reset_wr_count4: got %0d exp 0", wr_count4); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [7:0] exp_v [4];
    exp_v[0] = 8'hA1; exp_v[1] = 8'hB2; exp_v[2] = 8'hC3; exp_v[3] = 8'hD4;
    rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wr_sel = 4'b0001 << i;
      wr_data = exp_v[i];
      tick();
    end
    wr_sel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i);
      rd_addr_b = 2'(3 - i);
      tick();
      n_chk++; if (rd_data_a !== exp_v[i]) $display("FAIL read_a%0d: got %h exp %h", i, rd_data_a, exp_v[i]); else n_pass++;
      n_chk++; if (rd_data_b !== exp_v[3-i]) $display("FAIL read_b%0d: got %h exp %h", 3 - i, rd_data_b, exp_v[3-i]); else n_pass++;
    end
    n_chk++; if (wr_count !== 8'd4) $display("FAIL write_count: got %0d exp 4", wr_count); else n_pass++;
  endtask

  task automatic test_bypass();
    rd_addr_a = 2'd2; rd_addr_b = 2'd2;
    wr_sel = 4'b0100; wr_data = 8'h5A;
    tick();
    n_chk++; if (rd_data_a !== 8'h5A) $display("FAIL bypass_a: got %h exp 5a", rd_data_a); else n_pass++;
    n_chk++; if (rd_data_b !== 8'h5A) $display("FAIL bypass_b: got %h exp 5a", rd_data_b); else n_pass++;
    n_chk++; if (wr_count !== 8'd5) $display("FAIL bypass_count: got %0d exp 5", wr_count); else n_pass++;
    wr_sel = 4'b0000;
  endtask

  task automatic test_back_to_back();
    rd_addr_a = 2'd0; rd_addr_b = 2'd1;
    wr_sel = 4'b1000; wr_data = 8'h11; tick();
    wr_sel = 4'b1000; wr_data = 8'h22; tick();
    wr_sel = 4'b0000; rd_addr_a = 2'd3; tick();
    n_chk++; if (rd_data_a !== 8'h22) $display("FAIL b2b_last_wins: got %h exp 22", rd_data_a); else n_pass++;
    n_chk++; if (wr_count !== 8'd7) $display("FAIL b2b_count: got %0d exp 7", wr_count); else n_pass++;
  endtask

  task automatic test_illegal();
    rd_addr_a = 2'd1; rd_addr_b = 2'd2;
    wr_sel = 4'b0110; wr_data = 8'hFF;
    tick();
    n_chk++; if (rd_data_a !== 8'hB2) $display("FAIL illegal_e1: got %h exp b2", rd_data_a); else n_pass++;
    n_chk++; if (rd_data_b !== 8'h5A) $display("FAIL illegal_e2: got %h exp 5a", rd_data_b); else n_pass++;
    n_chk++; if (sel_err !== 1'b1) $display("FAIL illegal_set: got %b exp 1", sel_err); else n_pass++;
    n_chk++; if (wr_count !== 8'd7) $display("FAIL illegal_count: got %0d exp 7", wr_count); else n_pass++;
    wr_sel = 4'b0000; tick();
    n_chk++; if (sel_err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", sel_err); else n_pass++;
    n_chk++; if (rd_data_a !== 8'hB2) $display("FAIL illegal_e1_after: got %h exp b2", rd_data_a); else n_pass++;
    err_clr = 1'b1; tick();
    n_chk++; if (sel_err !== 1'b0) $display("FAIL err_clear: got %b exp 0", sel_err); else n_pass++;
    wr_sel = 4'b1111; tick();
    n_chk++; if (sel_err !== 1'b1) $display("FAIL err_set_wins: got %b exp 1", sel_err); else n_pass++;
    n_chk++; if (wr_count !== 8'd7) $display("FAIL illegal1111_count: got %0d exp 7", wr_count); else n_pass++;
    wr_sel = 4'b0000; err_clr = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 17; i++) begin
      wr_sel4 = 4'b0001 << (i % 4);
      wr_data4 = 8'(i);
      tick();
      if (i == 15) begin
        n_chk++; if (wr_count4 !== 4'd15) $display("FAIL wrap_15: got %0d exp 15", wr_count4); else n_pass++;
      end else if (i == 16) begin
        n_chk++; if (wr_count4 !== 4'd0) $display("FAIL wrap_0: got %0d exp 0", wr_count4); else n_pass++;
      end else if (i == 17) begin
        n_chk++; if (wr_count4 !== 4'd1) $display("FAIL wrap_1: got %0d exp 1", wr_count4); else n_pass++;
      end
    end
    wr_sel4 = 4'b0000;
  endtask

  task automatic test_reset_mid();
    // Entries currently hold A1, B2, 5A, 22; set the error flag as well.
    wr_sel = 4'b0011; tick();
    n_chk++; if (sel_err !== 1'b1) $display("FAIL pre_reset_err: got %b exp 1", sel_err); else n_pass++;
    rst_n = 1'b0; wr_sel = 4'b0001; wr_data = 8'h77; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    tick();
    n_chk++; if (sel_err !== 1'b0) $display("FAIL midreset_err: got %b exp 0", sel_err); else n_pass++;
    n_chk++; if (wr_count !== 8'd0) $display("FAIL midreset_count: got %0d exp 0", wr_count); else n_pass++;
    n_chk++; if (rd_data_a !== 8'h00) $display("FAIL midreset_rd_a: got %h exp 00", rd_data_a); else n_pass++;
    rst_n = 1'b1; wr_sel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
      tick();
      n_chk++; if (rd_data_a !== 8'h00) $display("FAIL postreset_a%0d: got %h exp 00", i, rd_data_a); else n_pass++;
      n_chk++; if (rd_data_b !== 8'h00) $display("FAIL postreset_b%0d: got %h exp 00", 3 - i, rd_data_b); else n_pass++;
    end
    n_chk++; if (wr_count !== 8'd0) $display("FAIL postreset_count: got %0d exp 0", wr_count); else n_pass++;
  endtask

  task automatic test_decoder_idle();
    logic [7:0] vals [4];
    vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40;
    rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wr_sel = dec2to4(1'b1, 2'(i)); wr_data = vals[i]; tick();
    end
    n_chk++; if (wr_count !== 8'd4) $display("FAIL dec_fill_count: got %0d exp 4", wr_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      wr_sel = dec2to4(1'b0, 2'(i)); wr_data = 8'hEE; tick();
    end
    wr_sel = 4'b0000;
    n_chk++; if (wr_count !== 8'd4) $display("FAIL dec_idle_count: got %0d exp 4", wr_count); else n_pass++;
    n_chk++; if (sel_err !== 1'b0) $display("FAIL dec_idle_err: got %b exp 0", sel_err); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(i);
      tick();
      n_chk++; if (rd_data_a !== vals[i]) $display("FAIL dec_idle_a%0d: got %h exp %h", i, rd_data_a, vals[i]); else n_pass++;
      n_chk++; if (rd_data_b !== vals[i]) $display("FAIL dec_idle_b%0d: got %h exp %h", i, rd_data_b, vals[i]); else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_decoder_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
